// File: rtl/bcd_dabble_conv_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encodings, the overflow digit pattern and the range helper.
package bcd_dabble_conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Digit shown on every position when the sample cannot be represented.
  localparam logic [3:0] BCD_ERR_DIGIT = 4'hE;

  // Largest value representable in the given number of decimal digits.
  function automatic int unsigned bcd_max_val(input int digits);
    int unsigned p;
    p = 1;
    for (int i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD nibble: values of 5 or more get +3
// so the following left shift carries correctly into the next decimal digit.
module bcd_add3_digit (
  input  logic [3:0] digit,
  output logic [3:0] corrected
);

  // Inputs are 0..9 during a valid conversion, so the sum never exceeds 12.
  assign corrected = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bcd_dabble_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with valid/ready handshakes on both sides and an "EEE" overflow pattern.
module bcd_dabble_conv
  import bcd_dabble_conv_pkg::*;
#(
  parameter int IN_WIDTH = 10,
  parameter int DIGITS   = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_ovf
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + IN_WIDTH;
  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam int unsigned MAX_VAL = bcd_max_val(DIGITS);
  localparam logic [31:0] MAX_VAL_W = 32'(MAX_VAL);
  localparam logic [CW-1:0] LAST_COUNT = CW'(IN_WIDTH - 1);

  state_t          state_reg, state_next;
  logic [SW-1:0]   shift_reg;
  logic [CW-1:0]   count_reg;
  logic [BW-1:0]   out_bcd_reg;
  logic            out_ovf_reg;

  logic [31:0]     in_data_ext;
  logic            accept;
  logic            too_big;
  logic            last_shift;
  logic [BW-1:0]   adj_bcd;
  logic [SW-1:0]   adjusted;
  logic [SW-1:0]   shifted;

  assign in_data_ext = {{(32 - IN_WIDTH){1'b0}}, in_data};
  assign too_big     = (in_data_ext > MAX_VAL_W);
  assign accept      = in_valid && in_ready;
  assign last_shift  = (count_reg == LAST_COUNT);

  // All nibbles of the BCD field are corrected in parallel before the shift.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit     (shift_reg[IN_WIDTH + 4*gi +: 4]),
      .corrected (adj_bcd[4*gi +: 4])
    );
  end

  assign adjusted = {adj_bcd, shift_reg[IN_WIDTH-1:0]};
  assign shifted  = adjusted << 1;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = too_big ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_shift) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; in_ready is forced low while reset is held.
  always_comb begin
    in_ready  = resetn && (state_reg == ST_IDLE);
    out_valid = (state_reg == ST_DONE);
  end

  // Datapath: shift register, counter and held result
  always_ff @(posedge clk) begin
    if (!resetn) begin
      shift_reg   <= '0;
      count_reg   <= '0;
      out_bcd_reg <= '0;
      out_ovf_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (too_big) begin
              out_bcd_reg <= {DIGITS{BCD_ERR_DIGIT}};
              out_ovf_reg <= 1'b1;
            end else begin
              shift_reg <= {{BW{1'b0}}, in_data};
              count_reg <= '0;
            end
          end
        end
        ST_SHIFT: begin
          shift_reg <= shifted;
          count_reg <= count_reg + CW'(1);
          if (last_shift) begin
            out_bcd_reg <= shifted[SW-1 -: BW];
            out_ovf_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_bcd = out_bcd_reg;
  assign out_ovf = out_ovf_reg;

endmodule

// File: tb/tb_bcd_dabble_conv.sv
// Directed bench for bcd_dabble_conv: handshakes, latency, overflow,
// back-pressure, reset abort and a full 0..1023 sweep against a decimal model.
module tb_bcd_dabble_conv;

  localparam int IN_WIDTH = 10;
  localparam int DIGITS   = 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_bcd;
  logic        out_ovf;

  int total = 0;
  int bad   = 0;

  bcd_dabble_conv #(.IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: division-based, independent of the shift-and-add algorithm.
  function automatic logic [11:0] ref_bcd(input int v);
    logic [11:0] r;
    if (v > 999) begin
      r = 12'hEEE;
    end else begin
      r = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    end
    return r;
  endfunction

  // One full transaction; hold = cycles to withhold out_ready once the result is up.
  task automatic do_txn(input int val, input int hold, input bit verbose);
    logic [11:0] exp_bcd;
    logic        exp_ovf;
    int          n;
    int          lat;
    exp_bcd = ref_bcd(val);
    exp_ovf = (val > 999);
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("ready_before_accept", 32'(in_ready), 32'd1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    in_data   = 10'(val);
    step();
    in_valid  = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      chk("busy_in_ready", 32'(in_ready), 32'd0);
      step();
      lat++;
    end
    chk("latency", 32'(lat), exp_ovf ? 32'd0 : 32'(IN_WIDTH));
    chk("out_bcd", 32'(out_bcd), 32'(exp_bcd));
    chk("out_ovf", 32'(out_ovf), 32'(exp_ovf));
    chk("done_in_ready", 32'(in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_bcd", 32'(out_bcd), 32'(exp_bcd));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("handover_valid", 32'(out_valid), 32'd0);
    chk("handover_in_ready", 32'(in_ready), 32'd1);
    if (verbose) begin
      $display("txn in=%0d bcd=%03h ovf=%0d lat=%0d", val, out_bcd, out_ovf, lat);
    end
  endtask

  initial begin
    int lat;
    int seen;
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_bcd", 32'(out_bcd), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    resetn = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);

    // Basic, back-to-back, overflow and back-pressure transactions
    do_txn(123, 0, 1'b1);
    do_txn(0, 0, 1'b1);
    do_txn(999, 0, 1'b1);
    do_txn(1000, 0, 1'b1);
    do_txn(1023, 0, 1'b1);
    do_txn(321, 5, 1'b1);

    // A second sample presented during SHIFT must wait for IDLE
    in_valid = 1'b1;
    in_data  = 10'd456;
    step();
    in_data  = 10'd789;
    lat = 0;
    while (!out_valid && lat < 40) begin
      chk("pending_in_ready", 32'(in_ready), 32'd0);
      step();
      lat++;
    end
    chk("first_bcd", 32'(out_bcd), 32'h456);
    step();
    chk("idle_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    chk("second_latency", 32'(lat), 32'd10);
    chk("second_bcd", 32'(out_bcd), 32'h789);
    $display("txn in=456,789 bcd=%03h", out_bcd);
    step();

    // Reset partway through the shift: the sample is dropped
    in_valid = 1'b1;
    in_data  = 10'd555;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    resetn = 1'b0;
    step();
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_bcd", 32'(out_bcd), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (out_valid) seen++;
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    $display("txn in=555 aborted by reset");
    do_txn(42, 0, 1'b1);

    // Full-range sweep against the decimal model
    for (int v = 0; v < 1024; v++) begin
      do_txn(v, 0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
